// File: rtl/fir_sample_feeder.sv
// Upstream feeder for myFIR: buffers a valid/ready sample stream in a FIFO and issues
// one sample at a time, waiting for the FIR's outputValid (with a stall watchdog).
`timescale 1ns/1ps

module fir_sample_feeder #(
  parameter int unsigned InputWidth = 16,
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned CountWidth = 32,
  parameter int unsigned Timeout    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic [InputWidth-1:0]        s_data,
  output logic                         s_ready,
  output logic                         fir_input_valid,
  output logic [InputWidth-1:0]        fir_input,
  input  logic                         fir_output_valid,
  output logic                         busy,
  output logic [$clog2(FifoDepth):0]   fifo_count,
  output logic [CountWidth-1:0]        sample_count,
  output logic                         timeout_err
);

  localparam int unsigned PtrWidth   = $clog2(FifoDepth);
  localparam int unsigned CntWidth   = PtrWidth + 1;
  localparam int unsigned TimerWidth = $clog2(Timeout + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [InputWidth-1:0]  mem [FifoDepth];
  logic [PtrWidth-1:0]    wr_ptr, rd_ptr;
  logic [TimerWidth-1:0]  timer_q, timer_d;
  logic                   push, pop, done, expire;

  // Ready is held low while reset is asserted so nothing is accepted mid-reset.
  assign s_ready = rst && (fifo_count != CntWidth'(FifoDepth));
  assign push    = s_valid && s_ready;

  // Next-state logic; the watchdog fires on the Timeout-th BUSY cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: begin
        state_d = BUSY;
        timer_d = '0;
      end
      BUSY: begin
        timer_d = timer_q + TimerWidth'(1);
        if (fir_output_valid) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (timer_q == TimerWidth'(Timeout - 1)) begin
          state_d = IDLE;
          expire  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CntWidth'(1);
        2'b01:   fifo_count <= fifo_count - CntWidth'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered outputs toward the FIR and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_input_valid <= 1'b0;
      fir_input       <= '0;
      busy            <= 1'b0;
      sample_count    <= '0;
      timeout_err     <= 1'b0;
    end else begin
      fir_input_valid <= (state_d == ISSUE);
      busy            <= (state_d != IDLE);
      if (pop)    fir_input    <= mem[rd_ptr];
      if (done)   sample_count <= sample_count + CountWidth'(1);
      if (expire) timeout_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder with a simple delayed-reply FIR model.
`timescale 1ns/1ps

module tb_fir_sample_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        fir_input_valid;
  logic [15:0] fir_input;
  logic        fir_output_valid;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [31:0] sample_count;
  logic        timeout_err;

  logic        resp_ov = 1'b0;
  logic        manual_ov = 1'b0;
  bit          reply_en = 1'b0;
  int          reply_delay = 5;
  logic [15:0] issued_q[$];
  int          pulses = 0;
  int          checks = 0;
  int          failures = 0;

  assign fir_output_valid = resp_ov | manual_ov;

  fir_sample_feeder #(
    .InputWidth(16), .FifoDepth(8), .CountWidth(32), .Timeout(255)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_input_valid(fir_input_valid), .fir_input(fir_input),
    .fir_output_valid(fir_output_valid), .busy(busy), .fifo_count(fifo_count),
    .sample_count(sample_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // FIR model: logs each issued sample and replies reply_delay edges after ISSUE.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (fir_input_valid) begin
        issued_q.push_back(fir_input);
        pulses++;
        if (reply_en) begin
          repeat (reply_delay) @(posedge clk);
          #1 resp_ov = 1'b1;
          @(posedge clk);
          #1 resp_ov = 1'b0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (!busy && fifo_count == 4'd0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks++; if (fir_input_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", fir_input_valid); end
    checks++; if (fir_input !== 16'h0) begin failures++; $display("FAIL rst_input got=%h want=0000", fir_input); end
    checks++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin failures++; $display("FAIL rst_busy_cnt got=%b/%0d want=0/0", busy, fifo_count); end
    checks++; if (sample_count !== 32'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_cnt_err got=%0d/%b want=0/0", sample_count, timeout_err); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_single();
    bit ok;
    reply_en = 1'b1; reply_delay = 5; issued_q.delete();
    push(16'h1234);
    checks++; if (fifo_count !== 4'd1 || fir_input_valid !== 1'b0) begin failures++; $display("FAIL single_e0 got=%0d/%b want=1/0", fifo_count, fir_input_valid); end
    @(posedge clk); #1;
    checks++; if (fir_input_valid !== 1'b1 || fir_input !== 16'h1234) begin failures++; $display("FAIL single_issue got=%b/%h want=1/1234", fir_input_valid, fir_input); end
    checks++; if (busy !== 1'b1 || fifo_count !== 4'd0) begin failures++; $display("FAIL single_busy got=%b/%0d want=1/0", busy, fifo_count); end
    @(posedge clk); #1;
    checks++; if (fir_input_valid !== 1'b0 || busy !== 1'b1 || fir_input !== 16'h1234) begin failures++; $display("FAIL single_pulse got=%b/%b/%h want=0/1/1234", fir_input_valid, busy, fir_input); end
    checks++; if (sample_count !== 32'd0) begin failures++; $display("FAIL single_early_cnt got=%0d want=0", sample_count); end
    wait_quiet(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done got=busy want=idle"); end
    checks++; if (sample_count !== 32'd1 || issued_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d/%0d want=1/1", sample_count, issued_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok, hs, saw_full, bad;
    int i, guard, order_err;
    reply_delay = 64; issued_q.delete();
    saw_full = 0; bad = 0; i = 0; guard = 0; order_err = 0;
    while (i < 10 && guard < 300) begin
      s_data  = 16'h0100 + 16'(i);
      s_valid = 1'b1;
      hs = s_ready;
      if (fifo_count == 4'd8 && !s_ready) saw_full = 1;
      if (fifo_count == 4'd8 && s_ready) bad = 1;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    s_valid = 1'b0;
    checks++; if (i != 10) begin failures++; $display("FAIL b2b_accepted got=%0d want=10", i); end
    checks++; if (!saw_full || bad) begin failures++; $display("FAIL b2b_full got=saw%0d/bad%0d want=saw1/bad0", saw_full, bad); end
    wait_quiet(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_drain got=busy want=idle"); end
    checks++; if (sample_count !== 32'd11 || issued_q.size() != 10) begin failures++; $display("FAIL b2b_count got=%0d/%0d want=11/10", sample_count, issued_q.size()); end
    for (int k = 0; k < issued_q.size(); k++) if (issued_q[k] !== 16'h0100 + 16'(k)) order_err++;
    checks++; if (order_err != 0) begin failures++; $display("FAIL b2b_order got=%0d_errors want=0", order_err); end
  endtask

  task automatic test_push_pop();
    bit ok, found;
    int order_err;
    logic [15:0] exp_q[$];
    reply_delay = 20; issued_q.delete(); order_err = 0; found = 0;
    exp_q = '{16'h0300, 16'h0301, 16'h0302, 16'h0303, 16'h0304};
    for (int k = 0; k < 4; k++) push(16'h0300 + 16'(k));
    checks++; if (fifo_count !== 4'd3) begin failures++; $display("FAIL pp_fill got=%0d want=3", fifo_count); end
    for (int n = 0; n < 100 && !found; n++) begin
      if (!busy) found = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!found || fifo_count !== 4'd3) begin failures++; $display("FAIL pp_idle got=%0d/%0d want=1/3", found, fifo_count); end
    push(16'h0304);
    checks++; if (fifo_count !== 4'd3 || fir_input_valid !== 1'b1 || fir_input !== 16'h0301) begin failures++; $display("FAIL pp_same_cycle got=%0d/%b/%h want=3/1/0301", fifo_count, fir_input_valid, fir_input); end
    wait_quiet(1000, ok);
    checks++; if (!ok || sample_count !== 32'd16) begin failures++; $display("FAIL pp_count got=%0d/%0d want=1/16", ok, sample_count); end
    if (issued_q.size() != 5) order_err++;
    else for (int k = 0; k < 5; k++) if (issued_q[k] !== exp_q[k]) order_err++;
    checks++; if (order_err != 0) begin failures++; $display("FAIL pp_order got=%0d_errors want=0", order_err); end
  endtask

  task automatic test_timeout();
    bit ok;
    reply_en = 1'b0; issued_q.delete();
    push(16'hAAAA);
    push(16'hBBBB);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_start got=%b/%b want=1/0", busy, timeout_err); end
    repeat (254) @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_early got=%b/%b want=1/0", busy, timeout_err); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin failures++; $display("FAIL to_fire got=%b/%b want=0/1", busy, timeout_err); end
    @(posedge clk); #1;
    checks++; if (fir_input_valid !== 1'b1 || fir_input !== 16'hBBBB) begin failures++; $display("FAIL to_next got=%b/%h want=1/bbbb", fir_input_valid, fir_input); end
    checks++; if (sample_count !== 32'd16) begin failures++; $display("FAIL to_count got=%0d want=16", sample_count); end
    wait_quiet(600, ok);
    checks++; if (!ok || timeout_err !== 1'b1 || sample_count !== 32'd16) begin failures++; $display("FAIL to_sticky got=%0d/%b/%0d want=1/1/16", ok, timeout_err, sample_count); end
  endtask

  task automatic test_reset_busy();
    bit ok, seen;
    int pulses_before;
    reply_en = 1'b0; seen = 0;
    for (int k = 0; k < 5; k++) push(16'h0500 + 16'(k));
    checks++; if (busy !== 1'b1 || fifo_count !== 4'd4) begin failures++; $display("FAIL rb_pre got=%b/%0d want=1/4", busy, fifo_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || fifo_count !== 4'd0 || s_ready !== 1'b0) begin failures++; $display("FAIL rb_async got=%b/%0d/%b want=0/0/0", busy, fifo_count, s_ready); end
    checks++; if (fir_input_valid !== 1'b0 || fir_input !== 16'h0) begin failures++; $display("FAIL rb_fir got=%b/%h want=0/0000", fir_input_valid, fir_input); end
    checks++; if (sample_count !== 32'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rb_stat got=%0d/%b want=0/0", sample_count, timeout_err); end
    @(negedge clk) rst = 1'b1;
    pulses_before = pulses;
    repeat (10) begin
      @(posedge clk); #1;
      if (fir_input_valid || fifo_count != 4'd0 || busy) seen = 1;
    end
    checks++; if (seen || pulses != pulses_before || s_ready !== 1'b1) begin failures++; $display("FAIL rb_quiet got=%0d/%0d/%b want=0/%0d/1", seen, pulses, s_ready, pulses_before); end
    reply_en = 1'b1; reply_delay = 3;
    push(16'h0600);
    @(posedge clk); #1;
    checks++; if (fir_input_valid !== 1'b1 || fir_input !== 16'h0600) begin failures++; $display("FAIL rb_new got=%b/%h want=1/0600", fir_input_valid, fir_input); end
    wait_quiet(100, ok);
    checks++; if (!ok || sample_count !== 32'd1) begin failures++; $display("FAIL rb_count got=%0d/%0d want=1/1", ok, sample_count); end
  endtask

  task automatic test_idle_ignore();
    int pulses_before;
    pulses_before = pulses;
    manual_ov = 1'b1;
    @(posedge clk); #1;
    manual_ov = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (sample_count !== 32'd1 || busy !== 1'b0) begin failures++; $display("FAIL idle_ov got=%0d/%b want=1/0", sample_count, busy); end
    checks++; if (pulses != pulses_before || timeout_err !== 1'b0) begin failures++; $display("FAIL idle_side got=%0d/%b want=%0d/0", pulses, timeout_err, pulses_before); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_push_pop();
    test_timeout();
    test_reset_busy();
    test_idle_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
